// File: rtl/vga_scan_driver.sv
// VGA raster timing generator: scan counters for the pixel plotter, blank-gated
// registered RGB, active-low syncs, vblank level and a one-clk frame_done pulse.
module vga_scan_driver #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_red,
  input  logic [3:0] data_green,
  input  logic [3:0] data_blue,
  output logic [9:0] rows,
  output logic [9:0] columns,
  output logic [3:0] vga_red,
  output logic [3:0] vga_green,
  output logic [3:0] vga_blue,
  output logic       hsync,
  output logic       vsync,
  output logic       vblank,
  output logic       frame_done
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] V_VIS_M1 = 10'(V_VISIBLE - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       col_q, col_d;
  logic [9:0]       row_q, row_d;
  logic [3:0]       rgb_q [3];
  logic [3:0]       rgb_d [3];
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_done_q, frame_done_d;
  logic             pix_en;
  logic             visible;
  logic [3:0]       data_ch [3];
  logic [3:0]       gated   [3];

  assign data_ch[0] = data_red;
  assign data_ch[1] = data_green;
  assign data_ch[2] = data_blue;

  assign visible = (col_q < H_VIS) && (row_q < V_VIS);

  // Plotter colour is forced to black outside the visible window.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_blank
      assign gated[gi] = visible ? data_ch[gi] : 4'h0;
    end
  endgenerate

  always_comb begin
    pix_en       = (div_q == DIV_LAST);
    div_d        = pix_en ? '0 : div_q + 1'b1;
    col_d        = col_q;
    row_d        = row_q;
    rgb_d        = rgb_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    frame_done_d = 1'b0;
    if (pix_en) begin
      if (col_q == H_LAST) begin
        col_d = '0;
        row_d = (row_q == V_LAST) ? '0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
      rgb_d        = gated;
      hsync_d      = ~((col_q >= HS_FIRST) && (col_q <= HS_LAST));
      vsync_d      = ~((row_q >= VS_FIRST) && (row_q <= VS_LAST));
      frame_done_d = (row_q == V_VIS_M1) && (col_q == H_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      rgb_q        <= '{default: 4'h0};
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      col_q        <= col_d;
      row_q        <= row_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rows       = row_q;
  assign columns    = col_q;
  assign vga_red    = rgb_q[0];
  assign vga_green  = rgb_q[1];
  assign vga_blue   = rgb_q[2];
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign vblank     = (row_q >= V_VIS);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver on a shrunken raster; expected outputs are derived
// from the elapsed pixel count since reset release.
module tb_vga_scan_driver;

  localparam int CD = 2;
  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int MID_ROW = 5;
  localparam int MID_COL = HV + HF + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_red, data_green, data_blue;
  logic [9:0] rows, columns;
  logic [3:0] vga_red, vga_green, vga_blue;
  logic       hsync, vsync, vblank, frame_done;

  always #5 clk = ~clk;

  vga_scan_driver #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst),
    .data_red(data_red), .data_green(data_green), .data_blue(data_blue),
    .rows(rows), .columns(columns),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .hsync(hsync), .vsync(vsync), .vblank(vblank), .frame_done(frame_done)
  );

  int vectors = 0;
  int miscompares = 0;

  // model state: n = clk edges since release (0 while in reset)
  int n = 0;
  int clk_i = 0;
  logic [3:0] sr = 4'h0, sg = 4'h0, sb = 4'h0;
  int cur_row = 0, cur_col = 0;
  bit edge_rst;

  bit h_prev = 1'b1, v_prev = 1'b1;
  bit hf_ok = 1'b0, hl_ok = 1'b0, vf_ok = 1'b0, vl_ok = 1'b0;
  int h_fall = 0, v_fall = 0;
  int fd_seen = 0, fd_after = 0, last_fd_n = 0;
  bit fd_first = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int p, q, rq, cq;
    bit vis;
    logic [3:0] er, eg, eb;
    bit ehs, evs, efd;
    p = n / CD;
    cur_row = (p / HT) % VT;
    cur_col = p % HT;
    if (p == 0) begin
      er = 4'h0; eg = 4'h0; eb = 4'h0; ehs = 1'b1; evs = 1'b1;
    end else begin
      q   = p - 1;
      rq  = (q / HT) % VT;
      cq  = q % HT;
      vis = (cq < HV) && (rq < VV);
      er  = vis ? sr : 4'h0;
      eg  = vis ? sg : 4'h0;
      eb  = vis ? sb : 4'h0;
      ehs = !((cq >= HV + HF) && (cq < HV + HF + HS));
      evs = !((rq >= VV + VF) && (rq < VV + VF + VS));
    end
    efd = (n > 0) && (n % CD == 0) && (cur_row == VV) && (cur_col == 0);
    chk("rows", 32'(rows), 32'(cur_row));
    chk("columns", 32'(columns), 32'(cur_col));
    chk("vga_red", 32'(vga_red), 32'(er));
    chk("vga_green", 32'(vga_green), 32'(eg));
    chk("vga_blue", 32'(vga_blue), 32'(eb));
    chk("hsync", 32'(hsync), 32'(ehs));
    chk("vsync", 32'(vsync), 32'(evs));
    chk("vblank", 32'(vblank), 32'(cur_row >= VV));
    chk("frame_done", 32'(frame_done), 32'(efd));
  endtask

  task automatic measure();
    if (edge_rst) begin
      hf_ok = 1'b0; hl_ok = 1'b0; vf_ok = 1'b0; vl_ok = 1'b0;
      fd_first = 1'b1;
    end
    if (h_prev && !hsync) begin
      if (hf_ok) chk("hsync_period_clks", 32'(clk_i - h_fall), 32'(HT * CD));
      h_fall = clk_i; hf_ok = 1'b1; hl_ok = 1'b1;
    end
    if (!h_prev && hsync && hl_ok) chk("hsync_low_clks", 32'(clk_i - h_fall), 32'(HS * CD));
    if (v_prev && !vsync) begin
      if (vf_ok) chk("vsync_period_clks", 32'(clk_i - v_fall), 32'(HT * VT * CD));
      v_fall = clk_i; vf_ok = 1'b1; vl_ok = 1'b1;
    end
    if (!v_prev && vsync && vl_ok) chk("vsync_low_clks", 32'(clk_i - v_fall), 32'(VS * HT * CD));
    h_prev = hsync;
    v_prev = vsync;
    if (frame_done === 1'b1) begin
      fd_seen++;
      fd_after++;
      if (fd_first) chk("frame_done_after_release", 32'(n), 32'(VV * HT * CD));
      else chk("frame_done_period", 32'(n - last_fd_n), 32'(HT * VT * CD));
      fd_first  = 1'b0;
      last_fd_n = n;
    end
  endtask

  task automatic step();
    @(posedge clk);
    clk_i++;
    edge_rst = !rst;
    if (!rst) begin
      n = 0;
    end else begin
      n++;
      if (n % CD == 0) begin
        sr = data_red; sg = data_green; sb = data_blue;
      end
    end
    #1;
    check_outputs();
    measure();
    data_red   = 4'($urandom);
    data_green = 4'($urandom);
    data_blue  = 4'($urandom);
  endtask

  initial begin
    bit trig;
    rst = 1'b0;
    data_red = 4'hF; data_green = 4'hF; data_blue = 4'hF;
    repeat (3) step();
    rst = 1'b1;

    trig = 1'b0;
    for (int k = 0; k < 4 * HT * VT * CD && !trig; k++) begin
      step();
      if (fd_seen >= 1 && cur_row == MID_ROW && cur_col == MID_COL) trig = 1'b1;
    end
    chk("mid_frame_point_reached", 32'(trig), 32'd1);
    chk("hsync_low_at_mid_reset", 32'(hsync), 32'd0);

    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    fd_after = 0;
    repeat (HT * VT * CD + 100) step();
    chk("frame_done_count_after_reset", 32'(fd_after), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
